// File: rtl/dispatch_stage_pkg.sv
// Shared core definitions for the dispatch stage: widths and the rename-table entry.
package dispatch_stage_pkg;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned AREG_W    = 5;

  typedef struct packed {
    logic                 busy;
    logic [ROB_IDX_W-1:0] tag;
  } rename_entry_t;

endpackage

// File: rtl/rename_table.sv
// Per-architectural-register producer tracking: two read ports with commit bypass,
// one rename write and one commit clear; flush drops every busy bit.
module rename_table
  import dispatch_stage_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic [AREG_W-1:0]    rs1_addr_i,
  input  logic [AREG_W-1:0]    rs2_addr_i,
  output rename_entry_t        rs1_o,
  output rename_entry_t        rs2_o,
  input  logic                 ren_valid_i,
  input  logic [AREG_W-1:0]    ren_addr_i,
  input  logic [ROB_IDX_W-1:0] ren_tag_i,
  input  logic                 commit_valid_i,
  input  logic [AREG_W-1:0]    commit_addr_i,
  input  logic [ROB_IDX_W-1:0] commit_tag_i
);

  rename_entry_t [NUM_AREGS-1:0] table_q, table_d;
  logic                          commit_hit;

  // A commit only retires the mapping if it still names the committing ROB entry.
  assign commit_hit = commit_valid_i && table_q[commit_addr_i].busy &&
                      (table_q[commit_addr_i].tag == commit_tag_i);

  always_comb begin
    rs1_o = table_q[rs1_addr_i];
    rs2_o = table_q[rs2_addr_i];
    if (rs1_addr_i == '0 || (commit_hit && rs1_addr_i == commit_addr_i)) rs1_o.busy = 1'b0;
    if (rs2_addr_i == '0 || (commit_hit && rs2_addr_i == commit_addr_i)) rs2_o.busy = 1'b0;
  end

  always_comb begin
    table_d = table_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++) table_d[i].busy = 1'b0;
    end else begin
      if (commit_hit) table_d[commit_addr_i].busy = 1'b0;
      // Applied after the clear so a same-cycle rename of the register wins.
      if (ren_valid_i && ren_addr_i != '0) begin
        table_d[ren_addr_i].busy = 1'b1;
        table_d[ren_addr_i].tag  = ren_tag_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) table_q <= '0;
    else          table_q <= table_d;
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: ROB allocation handshake, source renaming lookup and a
// single registered issue slot towards the reservation stations.
module dispatch_stage
  import dispatch_stage_pkg::rename_entry_t;
#(
  parameter int unsigned ROB_IDX_W = dispatch_stage_pkg::ROB_IDX_W,
  parameter int unsigned NUM_AREGS = dispatch_stage_pkg::NUM_AREGS
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 inst_valid_i,
  output logic                 inst_ready_o,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          inst_i,
  input  logic [4:0]           rd_addr_i,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  input  logic                 rd_wen_i,
  input  logic                 rob_full_i,
  input  logic [ROB_IDX_W-1:0] rob_idx_i,
  output logic                 allocate_req_o,
  output logic [4:0]           prd_addr_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          inst_o,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output logic [ROB_IDX_W-1:0] iss_rob_idx_o,
  output logic [31:0]          iss_pc_o,
  output logic [31:0]          iss_inst_o,
  output logic                 iss_rs1_busy_o,
  output logic                 iss_rs2_busy_o,
  output logic [ROB_IDX_W-1:0] iss_rs1_tag_o,
  output logic [ROB_IDX_W-1:0] iss_rs2_tag_o,
  input  logic                 commit_valid_i,
  input  logic [ROB_IDX_W-1:0] commit_rob_idx_i,
  input  logic [4:0]           commit_prd_addr_i,
  input  logic                 flush_i,
  output logic [31:0]          dispatch_cnt_o
);

  logic                 accept;
  rename_entry_t        rs1_ent, rs2_ent;
  logic                 iss_valid_q, iss_valid_d;
  logic [ROB_IDX_W-1:0] iss_rob_idx_q, iss_rob_idx_d;
  logic [31:0]          iss_pc_q, iss_pc_d, iss_inst_q, iss_inst_d;
  rename_entry_t        iss_rs1_q, iss_rs1_d, iss_rs2_q, iss_rs2_d;
  logic [31:0]          cnt_q, cnt_d;

  always_comb begin
    inst_ready_o   = !rob_full_i && !flush_i && (!iss_valid_q || iss_ready_i);
    accept         = inst_valid_i && inst_ready_o;
    allocate_req_o = accept;
    prd_addr_o     = rd_wen_i ? rd_addr_i : '0;
    pc_o           = pc_i;
    inst_o         = inst_i;
  end

  rename_table u_rename_table (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rs1_o          (rs1_ent),
    .rs2_o          (rs2_ent),
    .ren_valid_i    (accept && rd_wen_i),
    .ren_addr_i     (rd_addr_i),
    .ren_tag_i      (rob_idx_i),
    .commit_valid_i (commit_valid_i && !flush_i),
    .commit_addr_i  (commit_prd_addr_i),
    .commit_tag_i   (commit_rob_idx_i)
  );

  always_comb begin
    iss_valid_d   = iss_valid_q;
    iss_rob_idx_d = iss_rob_idx_q;
    iss_pc_d      = iss_pc_q;
    iss_inst_d    = iss_inst_q;
    iss_rs1_d     = iss_rs1_q;
    iss_rs2_d     = iss_rs2_q;
    cnt_d         = cnt_q;
    if (flush_i) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d   = 1'b1;
      iss_rob_idx_d = rob_idx_i;
      iss_pc_d      = pc_i;
      iss_inst_d    = inst_i;
      iss_rs1_d     = rs1_ent;
      iss_rs2_d     = rs2_ent;
      cnt_d         = cnt_q + 32'd1;
    end else if (iss_ready_i) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      iss_valid_q   <= 1'b0;
      iss_rob_idx_q <= '0;
      iss_pc_q      <= '0;
      iss_inst_q    <= '0;
      iss_rs1_q     <= '0;
      iss_rs2_q     <= '0;
      cnt_q         <= '0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      iss_rob_idx_q <= iss_rob_idx_d;
      iss_pc_q      <= iss_pc_d;
      iss_inst_q    <= iss_inst_d;
      iss_rs1_q     <= iss_rs1_d;
      iss_rs2_q     <= iss_rs2_d;
      cnt_q         <= cnt_d;
    end
  end

  assign iss_valid_o    = iss_valid_q;
  assign iss_rob_idx_o  = iss_rob_idx_q;
  assign iss_pc_o       = iss_pc_q;
  assign iss_inst_o     = iss_inst_q;
  assign iss_rs1_busy_o = iss_rs1_q.busy;
  assign iss_rs2_busy_o = iss_rs2_q.busy;
  assign iss_rs1_tag_o  = iss_rs1_q.tag;
  assign iss_rs2_tag_o  = iss_rs2_q.tag;
  assign dispatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_dispatch_stage.sv
// Self-checking bench for dispatch_stage: directed scenarios then randomized traffic
// against a register-level reference model of the rename/issue behaviour.
module tb_dispatch_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        inst_valid_i, inst_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [4:0]  rd_addr_i, rs1_addr_i, rs2_addr_i;
  logic        rd_wen_i, rob_full_i;
  logic [4:0]  rob_idx_i;
  logic        allocate_req_o;
  logic [4:0]  prd_addr_o;
  logic [31:0] pc_o, inst_o;
  logic        iss_valid_o, iss_ready_i;
  logic [4:0]  iss_rob_idx_o;
  logic [31:0] iss_pc_o, iss_inst_o;
  logic        iss_rs1_busy_o, iss_rs2_busy_o;
  logic [4:0]  iss_rs1_tag_o, iss_rs2_tag_o;
  logic        commit_valid_i;
  logic [4:0]  commit_rob_idx_i, commit_prd_addr_i;
  logic        flush_i;
  logic [31:0] dispatch_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  bit          m_busy[32];
  logic [4:0]  m_tag[32];
  bit          m_iv, m_b1, m_b2;
  logic [4:0]  m_rob, m_t1, m_t2;
  logic [31:0] m_pc, m_inst, m_cnt;

  always #5 clk_i = ~clk_i;

  dispatch_stage #(.ROB_IDX_W(5), .NUM_AREGS(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .rd_addr_i(rd_addr_i), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rd_wen_i(rd_wen_i), .rob_full_i(rob_full_i), .rob_idx_i(rob_idx_i),
    .allocate_req_o(allocate_req_o), .prd_addr_o(prd_addr_o), .pc_o(pc_o), .inst_o(inst_o),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_rob_idx_o(iss_rob_idx_o),
    .iss_pc_o(iss_pc_o), .iss_inst_o(iss_inst_o), .iss_rs1_busy_o(iss_rs1_busy_o),
    .iss_rs2_busy_o(iss_rs2_busy_o), .iss_rs1_tag_o(iss_rs1_tag_o), .iss_rs2_tag_o(iss_rs2_tag_o),
    .commit_valid_i(commit_valid_i), .commit_rob_idx_i(commit_rob_idx_i),
    .commit_prd_addr_i(commit_prd_addr_i), .flush_i(flush_i), .dispatch_cnt_o(dispatch_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
    m_iv = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0;
    m_rob = '0; m_t1 = '0; m_t2 = '0;
    m_pc = '0; m_inst = '0; m_cnt = '0;
  endtask

  function automatic bit src_busy(input logic [4:0] r);
    bit retiring;
    retiring = commit_valid_i && !flush_i && commit_prd_addr_i == r && m_tag[r] == commit_rob_idx_i;
    return (r != 0) && m_busy[r] && !retiring;
  endfunction

  task automatic set_side_defaults();
    iss_ready_i = 1'b1; rob_full_i = 1'b0; flush_i = 1'b0;
    commit_valid_i = 1'b0; commit_rob_idx_i = '0; commit_prd_addr_i = '0;
  endtask

  task automatic inst(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit wen, input logic [4:0] rob);
    inst_valid_i = v; rd_addr_i = rd; rs1_addr_i = rs1; rs2_addr_i = rs2;
    rd_wen_i = wen; rob_idx_i = rob; pc_i = $urandom; inst_i = $urandom;
  endtask

  task automatic check_regs();
    check("iss_valid", iss_valid_o, m_iv);
    check("iss_rob_idx", iss_rob_idx_o, m_rob);
    check("iss_pc", iss_pc_o, m_pc);
    check("iss_inst", iss_inst_o, m_inst);
    check("rs1_busy", iss_rs1_busy_o, m_b1);
    check("rs2_busy", iss_rs2_busy_o, m_b2);
    if (m_b1) check("rs1_tag", iss_rs1_tag_o, m_t1);
    if (m_b2) check("rs2_tag", iss_rs2_tag_o, m_t2);
    check("dispatch_cnt", dispatch_cnt_o, m_cnt);
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    bit exp_rdy, acc, nb1, nb2;
    logic [4:0] nt1, nt2;
    #1;
    exp_rdy = !rob_full_i && !flush_i && (!m_iv || iss_ready_i);
    acc     = inst_valid_i && exp_rdy;
    check("inst_ready", inst_ready_o, exp_rdy);
    check("allocate_req", allocate_req_o, acc);
    check("prd_addr", prd_addr_o, rd_wen_i ? rd_addr_i : 5'd0);
    check("pc_o", pc_o, pc_i);
    check("inst_o", inst_o, inst_i);
    nb1 = src_busy(rs1_addr_i); nt1 = m_tag[rs1_addr_i];
    nb2 = src_busy(rs2_addr_i); nt2 = m_tag[rs2_addr_i];
    if (flush_i) m_iv = 1'b0;
    else if (acc) begin
      m_iv = 1'b1; m_rob = rob_idx_i; m_pc = pc_i; m_inst = inst_i;
      m_b1 = nb1; m_t1 = nt1; m_b2 = nb2; m_t2 = nt2;
    end else if (iss_ready_i) m_iv = 1'b0;
    if (acc) m_cnt = m_cnt + 1;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (commit_valid_i && m_busy[commit_prd_addr_i] && m_tag[commit_prd_addr_i] == commit_rob_idx_i)
        m_busy[commit_prd_addr_i] = 1'b0;
      if (acc && rd_wen_i && rd_addr_i != 0) begin
        m_busy[rd_addr_i] = 1'b1;
        m_tag[rd_addr_i]  = rob_idx_i;
      end
    end
    @(posedge clk_i); #1;
    check_regs();
    @(negedge clk_i);
    set_side_defaults();
  endtask

  initial begin
    logic [31:0] held_pc;
    reset_i = 1'b0;
    set_side_defaults();
    inst(0, 0, 0, 0, 0, 0);
    reset_model();
    @(negedge clk_i); @(negedge clk_i); #1;
    check("reset_iss_valid", iss_valid_o, 0);
    check("reset_cnt", dispatch_cnt_o, 0);
    check("reset_pc", iss_pc_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;

    // Rename, then same-register read-before-write
    inst(1, 5, 0, 0, 1, 3); step();
    check("first_iss_valid", iss_valid_o, 1);
    check("first_cnt", dispatch_cnt_o, 1);
    inst(1, 5, 5, 0, 1, 4); step();
    check("rs_eq_rd_busy", iss_rs1_busy_o, 1);
    check("rs_eq_rd_tag", iss_rs1_tag_o, 3);
    inst(0, 0, 0, 0, 0, 0); commit_valid_i = 1; commit_rob_idx_i = 3; commit_prd_addr_i = 5; step();
    inst(1, 0, 5, 0, 0, 6); step();
    check("stale_commit_busy", iss_rs1_busy_o, 1);
    check("stale_commit_tag", iss_rs1_tag_o, 4);

    // Commit bypass on a same-cycle lookup
    inst(1, 7, 0, 0, 1, 9); step();
    inst(1, 0, 0, 7, 0, 10); commit_valid_i = 1; commit_rob_idx_i = 9; commit_prd_addr_i = 7; step();
    check("commit_bypass", iss_rs2_busy_o, 0);

    // ROB full blocks allocation and renaming
    inst(1, 8, 0, 0, 1, 11); rob_full_i = 1; step();
    inst(1, 0, 8, 0, 0, 11); step();
    check("full_no_rename", iss_rs1_busy_o, 0);

    // Issue slot holds while the reservation stations stall
    inst(1, 0, 0, 0, 0, 12); step();
    held_pc = m_pc;
    for (int k = 0; k < 3; k++) begin
      inst(1, 6, 0, 0, 1, 13); iss_ready_i = 0; step();
      check("stall_hold_pc", iss_pc_o, held_pc);
    end
    inst(0, 0, 0, 0, 0, 0); step();

    // Register 0 is never renamed
    inst(1, 0, 0, 0, 1, 14); step();
    inst(1, 0, 0, 0, 0, 15); step();
    check("x0_rs1", iss_rs1_busy_o, 0);
    check("x0_rs2", iss_rs2_busy_o, 0);

    // Flush drops all mappings and the issue slot
    for (int r = 1; r <= 4; r++) begin
      inst(1, 5'(r), 0, 0, 1, 5'(16 + r)); step();
    end
    inst(1, 9, 0, 0, 1, 21); flush_i = 1; step();
    check("flush_iss_valid", iss_valid_o, 0);
    inst(1, 0, 1, 2, 0, 22); step();
    check("flush_r1", iss_rs1_busy_o, 0);
    check("flush_r2", iss_rs2_busy_o, 0);
    inst(1, 0, 3, 4, 0, 23); step();
    check("flush_r3", iss_rs1_busy_o, 0);
    check("flush_r4", iss_rs2_busy_o, 0);

    // Randomized traffic with an asynchronous reset midway
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        inst(1, 3, 1, 2, 1, 5'($urandom));
        #2 reset_i = 1'b0;
        #1;
        reset_model();
        check("async_rst_valid", iss_valid_o, 0);
        check("async_rst_cnt", dispatch_cnt_o, 0);
        check("async_rst_busy", iss_rs1_busy_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
      end
      inst(($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
           ($urandom % 4) != 0, 5'($urandom));
      iss_ready_i       = ($urandom % 4) != 0;
      rob_full_i        = ($urandom % 8) == 0;
      flush_i           = ($urandom % 32) == 0;
      commit_valid_i    = ($urandom % 2) != 0;
      commit_prd_addr_i = 5'($urandom % 8);
      commit_rob_idx_i  = (($urandom % 2) != 0) ? m_tag[commit_prd_addr_i] : 5'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
